// File: rtl/vc_sram_req_adapter_if.sv
// Memory request/response port and SRAM-side port of vc_sram_req_adapter.
// The slave modport is the adapter's view; master is the client/array side.
interface vc_sram_req_adapter_if #(
  parameter int p_data_nbits  = 32,
  parameter int p_num_entries = 256
);
  localparam int c_addr_nbits  = $clog2(p_num_entries);
  localparam int c_data_nbytes = (p_data_nbits + 7) / 8;

  logic                     req_val;
  logic                     req_rdy;
  logic                     req_type;
  logic [c_addr_nbits-1:0]  req_addr;
  logic [p_data_nbits-1:0]  req_data;
  logic [c_data_nbytes-1:0] req_byte_en;

  logic                     resp_val;
  logic                     resp_rdy;
  logic                     resp_type;
  logic [p_data_nbits-1:0]  resp_data;

  logic                     sram_read_en;
  logic [c_addr_nbits-1:0]  sram_read_addr;
  logic [p_data_nbits-1:0]  sram_read_data;
  logic                     sram_write_en;
  logic [c_data_nbytes-1:0] sram_write_byte_en;
  logic [c_addr_nbits-1:0]  sram_write_addr;
  logic [p_data_nbits-1:0]  sram_write_data;

  modport slave (
    input  req_val, req_type, req_addr, req_data, req_byte_en,
    input  resp_rdy, sram_read_data,
    output req_rdy, resp_val, resp_type, resp_data,
    output sram_read_en, sram_read_addr,
    output sram_write_en, sram_write_byte_en,
    output sram_write_addr, sram_write_data
  );

  modport master (
    output req_val, req_type, req_addr, req_data, req_byte_en,
    output resp_rdy, sram_read_data,
    input  req_rdy, resp_val, resp_type, resp_data,
    input  sram_read_en, sram_read_addr,
    input  sram_write_en, sram_write_byte_en,
    input  sram_write_addr, sram_write_data
  );
endinterface

// File: rtl/vc_sram_req_adapter.sv
// Val/rdy front end for a 1rw synchronous SRAM with a 3-entry
// in-order response queue that never drops read data.
module vc_sram_req_adapter #(
  parameter int p_data_nbits  = 32,
  parameter int p_num_entries = 256
) (
  input logic                   clk,
  input logic                   reset,
  vc_sram_req_adapter_if.slave  bus
);

  logic                    fire;
  logic                    enq;
  logic                    deq;
  logic [2:0]              credit;

  logic                    s1_val_q, s1_val_d;
  logic                    s1_type_q, s1_type_d;
  logic [1:0]              enq_ptr_q, enq_ptr_d;
  logic [1:0]              deq_ptr_q, deq_ptr_d;
  logic [1:0]              count_q, count_d;
  logic                    q_type_q [3];
  logic                    q_type_d [3];
  logic [p_data_nbits-1:0] q_data_q [3];
  logic [p_data_nbits-1:0] q_data_d [3];

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit covers both queued entries and the one in flight in S1
  assign credit      = {1'b0, count_q} + {2'b0, s1_val_q};
  assign bus.req_rdy = !reset && (credit < 3'd3);
  assign fire        = bus.req_val && bus.req_rdy;

  assign bus.sram_read_en       = fire && !bus.req_type;
  assign bus.sram_write_en      = fire && bus.req_type;
  assign bus.sram_read_addr     = bus.req_addr;
  assign bus.sram_write_addr    = bus.req_addr;
  assign bus.sram_write_data    = bus.req_data;
  assign bus.sram_write_byte_en = bus.req_byte_en;

  assign enq           = s1_val_q;
  assign bus.resp_val  = (count_q != 2'd0);
  assign bus.resp_type = q_type_q[deq_ptr_q];
  assign bus.resp_data = q_data_q[deq_ptr_q];
  assign deq           = bus.resp_val && bus.resp_rdy;

  always_comb begin
    s1_val_d  = fire;
    s1_type_d = bus.req_type;
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;
    q_type_d  = q_type_q;
    q_data_d  = q_data_q;
    if (enq) begin
      q_type_d[enq_ptr_q] = s1_type_q;
      q_data_d[enq_ptr_q] = s1_type_q ? '0 : bus.sram_read_data;
      enq_ptr_d           = ptr_inc(enq_ptr_q);
    end
    if (deq)
      deq_ptr_d = ptr_inc(deq_ptr_q);
    if (enq && !deq)
      count_d = count_q + 2'd1;
    else if (!enq && deq)
      count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_val_q  <= 1'b0;
      enq_ptr_q <= 2'd0;
      deq_ptr_q <= 2'd0;
      count_q   <= 2'd0;
    end else begin
      s1_val_q  <= s1_val_d;
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

  // Payload storage is only read when its slot is counted valid
  always_ff @(posedge clk) begin
    s1_type_q <= s1_type_d;
    q_type_q  <= q_type_d;
    q_data_q  <= q_data_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown(bus.req_val));
      assert (!$isunknown(bus.resp_rdy));
      if (fire && bus.req_type) begin
        assert (!$isunknown(bus.req_addr));
        assert (!$isunknown(bus.req_byte_en));
      end
      if (fire)
        assert (32'(bus.req_addr) < 32'(p_num_entries));
      assert (!(enq && count_q == 2'd3));
    end
  end

endmodule

// File: tb/tb_vc_sram_req_adapter.sv
// Scoreboard bench for vc_sram_req_adapter with a behavioural SRAM
// and a reference memory evaluated at request-issue time.
module tb_vc_sram_req_adapter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_sram_req_adapter_if bus ();

  vc_sram_req_adapter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        t;
    logic [31:0] d;
  } rsp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stalls = 0;
  int          last_fire = 0;
  logic [31:0] last_data = '0;
  rsp_t        exp_q[$];
  int          pop_cyc_q[$];
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];

  logic rand_mode = 1'b0;
  logic rdy_force = 1'b1;
  logic rnd_bit = 1'b0;
  assign bus.resp_rdy = rand_mode ? rnd_bit : rdy_force;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1 rnd_bit = ($urandom % 2) == 1;
  end

  always @(posedge clk) begin
    if (bus.sram_write_en)
      for (int b = 0; b < 4; b++)
        if (bus.sram_write_byte_en[b])
          mem[bus.sram_write_addr][8*b +: 8] <= bus.sram_write_data[8*b +: 8];
    if (bus.sram_read_en)
      bus.sram_read_data <= mem[bus.sram_read_addr];
  end

  always @(negedge clk) begin
    rsp_t e;
    if (!reset && bus.resp_val && bus.resp_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_extra: got type=%0b data=%h, none expected",
                 bus.resp_type, bus.resp_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.resp_type !== e.t || bus.resp_data !== e.d) begin
          errors++;
          $display("FAIL resp: got type=%0b data=%h, want type=%0b data=%h",
                   bus.resp_type, bus.resp_data, e.t, e.d);
        end
      end
      pop_cyc_q.push_back(cyc);
      last_data = bus.resp_data;
    end
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", n, act, want);
    end
  endtask

  task automatic model(input logic t, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (t) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      exp_q.push_back('{t: 1'b1, d: 32'h0});
    end else begin
      exp_q.push_back('{t: 1'b0, d: ref_mem[a]});
    end
  endtask

  task automatic send(input logic t, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    bit ok = 0;
    bus.req_val     = 1'b1;
    bus.req_type    = t;
    bus.req_addr    = a;
    bus.req_data    = d;
    bus.req_byte_en = be;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_rdy) ok = 1;
      else begin
        stalls++;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: req_rdy=0, want 1 within 200 cycles");
    end else begin
      model(t, a, d, be);
      last_fire = cyc;
      @(posedge clk);
      #1;
    end
    bus.req_val = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.resp_val); i++)
      @(negedge clk);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fw;
    int idx;
    logic [31:0] head;
    bit stable;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    bus.req_val        = 1'b0;
    bus.req_type       = 1'b0;
    bus.req_addr       = '0;
    bus.req_data       = '0;
    bus.req_byte_en    = '0;
    bus.sram_read_data = '0;
    reset = 1'b1;

    @(negedge clk);
    chk("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_resp_val", 32'(bus.resp_val), 32'd0);
    chk("rst_req_rdy_after", 32'(bus.req_rdy), 32'd1);
    @(posedge clk);
    #1;

    // write then read, write response at N+2
    pop_cyc_q.delete();
    send(1'b1, 8'd5, 32'hDEADBEEF, 4'hF);
    fw = last_fire;
    send(1'b0, 8'd5, 32'h0, 4'h0);
    drain();
    chk("wr_latency", 32'(pop_cyc_q[0]), 32'(fw + 2));
    chk("wr_rd_data", last_data, 32'hDEADBEEF);

    // partial byte-enable write
    send(1'b1, 8'd2, 32'h11223344, 4'hF);
    send(1'b1, 8'd2, 32'hAABBCCDD, 4'b0101);
    send(1'b0, 8'd2, 32'h0, 4'h0);
    drain();
    chk("partial", last_data, 32'h11BB33DD);

    // streaming reads of addrs 0..7
    for (int i = 0; i < 8; i++)
      send(1'b1, 8'(i), 32'hC0DE0000 + 32'(i), 4'hF);
    drain();
    pop_cyc_q.delete();
    stalls = 0;
    for (int i = 0; i < 8; i++)
      send(1'b0, 8'(i), 32'h0, 4'h0);
    chk("stream_stalls", 32'(stalls), 32'd0);
    drain();
    chk("stream_count", 32'(pop_cyc_q.size()), 32'd8);
    chk("stream_span", 32'(pop_cyc_q[7] - pop_cyc_q[0]), 32'd7);
    chk("stream_last", last_data, 32'hC0DE0007);

    // backpressure: 5 reads offered, only 3 fit
    for (int i = 0; i < 5; i++)
      send(1'b1, 8'(10 + i), 32'h5A000000 + 32'(i * 17), 4'hF);
    drain();
    rdy_force = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      bus.req_val  = (idx < 5);
      bus.req_type = 1'b0;
      bus.req_addr = 8'(10 + idx);
      @(negedge clk);
      if (bus.req_val && bus.req_rdy) begin
        model(1'b0, 8'(10 + idx), 32'h0, 4'h0);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    bus.req_val = 1'b0;
    @(negedge clk);
    chk("bp_accepted", 32'(idx), 32'd3);
    chk("bp_req_rdy", 32'(bus.req_rdy), 32'd0);
    chk("bp_resp_val", 32'(bus.resp_val), 32'd1);
    chk("bp_head", bus.resp_data, 32'h5A000000);
    head = bus.resp_data;
    stable = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.resp_data !== head || !bus.resp_val) stable = 0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    @(posedge clk);
    #1;
    pop_cyc_q.delete();
    rdy_force = 1'b1;
    send(1'b0, 8'd13, 32'h0, 4'h0);
    send(1'b0, 8'd14, 32'h0, 4'h0);
    drain();
    chk("bp_total", 32'(pop_cyc_q.size()), 32'd5);
    chk("bp_last", last_data, 32'h5A000044);

    // reset with two reads outstanding
    rdy_force = 1'b0;
    send(1'b0, 8'd1, 32'h0, 4'h0);
    send(1'b0, 8'd2, 32'h0, 4'h0);
    reset = 1'b1;
    bus.req_val = 1'b1;
    @(negedge clk);
    chk("midrst_req_rdy", 32'(bus.req_rdy), 32'd0);
    chk("midrst_rd_en", 32'(bus.sram_read_en), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.req_val = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_resp_val", 32'(bus.resp_val), 32'd0);
    @(posedge clk);
    #1;
    rdy_force = 1'b1;
    pop_cyc_q.delete();
    send(1'b0, 8'd7, 32'h0, 4'h0);
    drain();
    chk("midrst_count", 32'(pop_cyc_q.size()), 32'd1);
    chk("midrst_data", last_data, 32'hC0DE0007);

    // random mix with random response backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 30; i++)
      send(1'($urandom % 2), 8'($urandom % 16), $urandom, 4'($urandom % 16));
    rand_mode = 1'b0;
    rdy_force = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
